// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx (and adopted by uart_tx).
//   uart_state_e      : frame FSM encoding IDLE/START/DATA/PARITY/STOP
//   MIN_BAUD_DIV      : smallest runtime divider accepted as-is
//   default_baud_div(): rounded clocks-per-bit from clock and baud rate
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int MIN_BAUD_DIV = 4;

  // Round to nearest rather than truncate so the bit period error stays
  // within half a clock.
  function automatic int default_baud_div(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
//   clk      : destination clock
//   rst      : synchronous active-high reset, both flops load RESET_VAL
//   async_in : asynchronous input
//   sync_out : input re-timed to clk (two-cycle latency)
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (or 8E1 with UART_RX_PARITY_EN), LSB first, mid-bit
// sampling timed by a runtime baud divider, byte delivered on valid/ready.
//   clk, rst   : system clock, synchronous active-high reset
//   rx         : asynchronous serial line
//   baud_div   : clocks per bit; values below 4 select the built-in default
//   rx_data    : received byte, held until accepted
//   rx_valid   : rx_data holds an unconsumed byte
//   rx_ready   : consumer accepts when rx_valid && rx_ready
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, new byte dropped because buffer was full
//   parity_err : (UART_RX_PARITY_EN only) one-cycle pulse, even parity wrong
//   busy       : receiver is inside a frame
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ       = 50000000,
  parameter int BAUD_RATE      = 115200,
  parameter int BAUD_DIV_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  input  logic [BAUD_DIV_WIDTH-1:0] baud_div,
  output logic [7:0]                rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
`ifdef UART_RX_PARITY_EN
  output logic                      parity_err,
`endif
  output logic                      busy
);

  localparam logic [BAUD_DIV_WIDTH-1:0] DEFAULT_BAUD_DIV =
    BAUD_DIV_WIDTH'(default_baud_div(CLK_FREQ, BAUD_RATE));
  localparam logic [BAUD_DIV_WIDTH-1:0] MIN_DIV = BAUD_DIV_WIDTH'(MIN_BAUD_DIV);
  localparam logic [BAUD_DIV_WIDTH-1:0] ONE     = BAUD_DIV_WIDTH'(1);

  logic rxs;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (rx),
    .sync_out (rxs)
  );

  uart_state_e               state_q, state_d;
  logic [BAUD_DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [BAUD_DIV_WIDTH-1:0] div_q, div_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [7:0]                shift_q, shift_d;
  logic                      armed_q, armed_d;
  logic [7:0]                rx_data_q, rx_data_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad_q, par_bad_d;
  logic                      parity_err_q, parity_err_d;
`endif

  logic [BAUD_DIV_WIDTH-1:0] eff_div;
  logic [BAUD_DIV_WIDTH-1:0] half_m1;
  logic [BAUD_DIV_WIDTH-1:0] div_m1;
  logic [BAUD_DIV_WIDTH-1:0] cnt_inc;
  logic                      byte_done;
  logic                      frame_bad;

  always_comb begin
    eff_div = (baud_div >= MIN_DIV) ? baud_div : DEFAULT_BAUD_DIV;
    half_m1 = (div_q >> 1) - ONE;
    div_m1  = div_q - ONE;
    cnt_inc = cnt_q + ONE;
  end

  // Frame FSM and bit timing
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    // Any high level on the line re-arms start detection.
    armed_d   = armed_q | rxs;
    byte_done = 1'b0;
    frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif

    case (state_q)
      IDLE: begin
        if (armed_q && !rxs) begin
          state_d = START;
          cnt_d   = '0;
          // The divider is frozen for the whole frame from here on.
          div_d   = eff_div;
        end
      end

      START: begin
        if (cnt_q == half_m1) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      DATA: begin
        if (cnt_q == div_m1) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == div_m1) begin
          cnt_d     = '0;
          // Even parity: data bits plus parity bit must XOR to zero.
          par_bad_d = ^{shift_q, rxs};
          state_d   = STOP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
`endif

      STOP: begin
        if (cnt_q == div_m1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxs) begin
            byte_done = 1'b1;
          end else begin
            frame_bad = 1'b1;
            // Line is low now; wait for it to go high before a new start.
            armed_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output buffer and status pulses
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_ready;
    overrun_d   = 1'b0;
    frame_err_d = frame_bad;
`ifdef UART_RX_PARITY_EN
    parity_err_d = byte_done & par_bad_q;
`endif
    if (byte_done) begin
      if (rx_valid_q && !rx_ready) begin
        // Buffer still owned by the consumer: keep the old byte.
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      bit_cnt_q   <= 3'd0;
      armed_q     <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      armed_q     <= armed_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // The shift register is pure datapath; every bit is rewritten before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CLK_FREQ  = 50000000;
  localparam int BAUD_RATE = 115200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] baud_div = 16'd16;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        frame_err;
  logic        overrun;
  logic        busy;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
`endif

  uart_rx #(
    .CLK_FREQ       (CLK_FREQ),
    .BAUD_RATE      (BAUD_RATE),
    .BAUD_DIV_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .baud_div  (baud_div),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed traffic, gathered away from the active edge.
  logic [7:0] hs_q[$];
  int         hs_cyc[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         pe_cnt = 0;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (rx_valid && rx_ready) begin
        hs_q.push_back(rx_data);
        hs_cyc.push_back(cyc);
      end
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference: clocks per bit the receiver must use for a given baud_div.
  function automatic int model_div(input int d);
    if (d >= 4) return d;
    return (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input int div, input bit bad_stop,
                            input bit bad_par, input bit scramble);
    int len;
    len = model_div(div);
    baud_div = 16'(div);
    rx = 1'b0;
    start_cyc = cyc;
    tick(len);
    if (scramble) baud_div = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(len);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ bad_par;
    tick(len);
`else
    if (bad_par) rx = 1'b1;
`endif
    rx = ~bad_stop;
    tick(len);
  endtask

  task automatic wait_hs(input int n, input int budget);
    int k;
    k = 0;
    while (hs_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    baud_div = 16'd16;
    tick(3);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_basic();
    int n0, fe0, lat, exp_lat;
    rx_ready = 1'b1;
    n0 = hs_q.size();
    fe0 = fe_cnt;
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0);
    idle(32);
    wait_hs(n0 + 1, 100);
    checks++;
    if (hs_q.size() != n0 + 1) begin
      errors++; $display("FAIL basic_count: got %0d bytes expected 1", hs_q.size() - n0);
    end else begin
      checks++; if (hs_q[n0] !== 8'h55) begin errors++; $display("FAIL basic_data: got %h expected 55", hs_q[n0]); end
      // 2 sync + 1 detect, half bit, 8 data + stop bits, 1 output register.
      lat = hs_cyc[n0] - start_cyc;
      exp_lat = 3 + 16 / 2 + 9 * 16 + 1;
      checks++;
      if (lat < exp_lat - 2 || lat > exp_lat + 2) begin
        errors++; $display("FAIL basic_latency: got %0d cycles expected %0d +-2", lat, exp_lat);
      end
    end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL basic_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_back_to_back();
    int n0, fe0, ov0;
    rx_ready = 1'b1;
    n0 = hs_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0);
    idle(32);
    wait_hs(n0 + 2, 100);
    checks++;
    if (hs_q.size() != n0 + 2) begin
      errors++; $display("FAIL b2b_count: got %0d bytes expected 2", hs_q.size() - n0);
    end else begin
      checks++; if (hs_q[n0] !== 8'hA5) begin errors++; $display("FAIL b2b_first: got %h expected a5", hs_q[n0]); end
      checks++; if (hs_q[n0+1] !== 8'h3C) begin errors++; $display("FAIL b2b_second: got %h expected 3c", hs_q[n0+1]); end
    end
    checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++; $display("FAIL b2b_errors: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_glitch();
    int n0;
    bit seen_busy;
    rx_ready = 1'b1;
    baud_div = 16'd16;
    n0 = hs_q.size();
    seen_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (busy === 1'b1) seen_busy = 1'b1;
    end
    rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (busy === 1'b1) seen_busy = 1'b1;
    end
    checks++; if (!seen_busy) begin errors++; $display("FAIL glitch_busy_seen: got busy never high expected high"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop: got %b expected 0", busy); end
    idle(200);
    checks++; if (hs_q.size() != n0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL glitch_no_byte: got %0d bytes valid=%b expected 0 0", hs_q.size() - n0, rx_valid);
    end
  endtask

  task automatic test_frame_err();
    int n0, fe0;
    rx_ready = 1'b1;
    n0 = hs_q.size(); fe0 = fe_cnt;
    send_frame(8'hFF, 16, 1'b1, 1'b0, 1'b0);
    idle(32);
    checks++; if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL ferr_pulse: got %0d pulses expected 1", fe_cnt - fe0); end
    checks++; if (hs_q.size() != n0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL ferr_no_byte: got %0d bytes valid=%b expected 0 0", hs_q.size() - n0, rx_valid);
    end
    send_frame(8'h12, 16, 1'b0, 1'b0, 1'b0);
    idle(32);
    wait_hs(n0 + 1, 100);
    checks++;
    if (hs_q.size() != n0 + 1) begin
      errors++; $display("FAIL ferr_next_count: got %0d bytes expected 1", hs_q.size() - n0);
    end else begin
      checks++; if (hs_q[n0] !== 8'h12) begin errors++; $display("FAIL ferr_next_data: got %h expected 12", hs_q[n0]); end
    end
    checks++; if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL ferr_once: got %0d pulses expected 1", fe_cnt - fe0); end
  endtask

  task automatic test_overrun();
    int n0, ov0;
    rx_ready = 1'b0;
    n0 = hs_q.size(); ov0 = ov_cnt;
    send_frame(8'h11, 16, 1'b0, 1'b0, 1'b0);
    idle(16);
    send_frame(8'h22, 16, 1'b0, 1'b0, 1'b0);
    idle(32);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      errors++; $display("FAIL ovr_hold: got valid=%b data=%h expected 1 11", rx_valid, rx_data);
    end
    checks++; if (ov_cnt != ov0 + 1) begin errors++; $display("FAIL ovr_pulse: got %0d pulses expected 1", ov_cnt - ov0); end
    rx_ready = 1'b1;
    tick(6);
    rx_ready = 1'b0;
    checks++;
    if (hs_q.size() != n0 + 1) begin
      errors++; $display("FAIL ovr_handshakes: got %0d expected 1", hs_q.size() - n0);
    end else begin
      checks++; if (hs_q[n0] !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h expected 11", hs_q[n0]); end
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_clear: got %b expected 0", rx_valid); end
  endtask

  task automatic test_reset_mid();
    int n0;
    rx_ready = 1'b0;
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0);
    idle(16);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rmid_buffered: got %b expected 1", rx_valid); end
    rx = 1'b0;
    tick(40);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b expected 1", busy); end
    rst = 1'b1;
    rx = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    checks++; if (rx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_cleared: got valid=%b busy=%b expected 0 0", rx_valid, busy);
    end
    idle(200);
    rx_ready = 1'b1;
    n0 = hs_q.size();
    send_frame(8'h6B, 16, 1'b0, 1'b0, 1'b0);
    idle(32);
    wait_hs(n0 + 1, 100);
    checks++;
    if (hs_q.size() != n0 + 1 || hs_q[hs_q.size()-1] !== 8'h6B) begin
      errors++; $display("FAIL rmid_after: got %0d bytes last=%h expected 1 6b", hs_q.size() - n0,
                         (hs_q.size() > 0) ? hs_q[hs_q.size()-1] : 8'hxx);
    end
  endtask

  task automatic test_fallback();
    int n0;
    rx_ready = 1'b1;
    n0 = hs_q.size();
    send_frame(8'hC3, 2, 1'b0, 1'b0, 1'b0);
    idle(model_div(2));
    wait_hs(n0 + 1, 1000);
    checks++;
    if (hs_q.size() != n0 + 1) begin
      errors++; $display("FAIL fallback_count: got %0d bytes expected 1", hs_q.size() - n0);
    end else begin
      checks++; if (hs_q[n0] !== 8'hC3) begin errors++; $display("FAIL fallback_data: got %h expected c3", hs_q[n0]); end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int n0, pe0, fe0;
    rx_ready = 1'b1;
    n0 = hs_q.size(); pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h07, 16, 1'b0, 1'b1, 1'b0);
    idle(32);
    wait_hs(n0 + 1, 100);
    checks++; if (pe_cnt != pe0 + 1) begin errors++; $display("FAIL parity_pulse: got %0d pulses expected 1", pe_cnt - pe0); end
    checks++;
    if (hs_q.size() != n0 + 1) begin
      errors++; $display("FAIL parity_count: got %0d bytes expected 1", hs_q.size() - n0);
    end else begin
      checks++; if (hs_q[n0] !== 8'h07) begin errors++; $display("FAIL parity_data: got %h expected 07", hs_q[n0]); end
    end
    pe0 = pe_cnt;
    send_frame(8'h07, 16, 1'b1, 1'b1, 1'b0);
    idle(32);
    checks++; if (pe_cnt != pe0 || fe_cnt != fe0 + 1) begin
      errors++; $display("FAIL parity_vs_frame: got pe=%0d fe=%0d expected 0 1", pe_cnt - pe0, fe_cnt - fe0);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int n0, fe0, pe0, exp_fe, div, gap;
    bit bad;
    rx_ready = 1'b1;
    n0 = hs_q.size(); fe0 = fe_cnt; pe0 = pe_cnt;
    exp_fe = 0;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      div = $urandom_range(4, 24);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, div, bad, 1'b0, 1'b1);
      if (bad) begin
        exp_fe++;
        gap = $urandom_range(1, 2);
      end else begin
        exp_q.push_back(b);
        gap = $urandom_range(0, 2);
      end
      idle(gap * div);
    end
    idle(64);
    wait_hs(n0 + exp_q.size(), 200);
    checks++;
    if (hs_q.size() != n0 + exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d bytes expected %0d", hs_q.size() - n0, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (hs_q[n0+i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, hs_q[n0+i], exp_q[i]);
        end
      end
    end
    checks++; if (fe_cnt != fe0 + exp_fe) begin errors++; $display("FAIL rand_frame_err: got %0d expected %0d", fe_cnt - fe0, exp_fe); end
    checks++; if (pe_cnt != pe0) begin errors++; $display("FAIL rand_parity_err: got %0d expected 0", pe_cnt - pe0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_random();
    test_fallback();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
